// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//
// Sequential 8x8 unsigned multiply controller. It borrows the shared 8-bit ALU
// (the select mux hands it over while o_busy is high) and walks the classic
// shift-add algorithm one ALU operation per cycle:
//   ADD      : {cy, acc} = acc + m           (only when the current q[0] is 1)
//   SHIFT_HI : acc = RRC(acc) through cy     (cy picks up the old acc[0])
//   SHIFT_LO : q   = RRC(q)   through cy     (one multiplier bit retired)
// After eight bits {acc, q} holds a*b and o_done pulses for one cycle.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      multiply request, sampled only while idle
//   i_a_in       multiplicand, captured on acceptance
//   i_b_in       multiplier, captured on acceptance
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse, product valid
//   o_product    {acc, q}, held until the next accepted start
//   o_alu_a      ALU operand A
//   o_alu_b      ALU operand B
//   o_alu_sel    ALU op select (NOP=0000, ADD=0010, RRC=0111)
//   o_alu_cin    ALU carry-in
//   i_alu_out    ALU result (combinational, same cycle)
//   i_alu_c      ALU carry flag (combinational, same cycle)
// -----------------------------------------------------------------------------
module alu_mul_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_a_in,
  input  logic [7:0]  i_b_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [3:0]  o_alu_sel,
  output logic        o_alu_cin,
  input  logic [7:0]  i_alu_out,
  input  logic        i_alu_c
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_RRC = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_m;
  logic [7:0]  r_acc;
  logic [7:0]  r_q;
  logic        r_cy;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  // Control and datapath registers. busy/done are registered alongside the
  // state transition so they track the state exactly without a decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_m     <= 8'h00;
      r_acc   <= 8'h00;
      r_q     <= 8'h00;
      r_cy    <= 1'b0;
      r_cnt   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m     <= i_a_in;
            r_q     <= i_b_in;
            r_acc   <= 8'h00;
            r_cy    <= 1'b0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= i_b_in[0] ? S_ADD : S_SHIFT_HI;
          end
        end
        S_ADD: begin
          r_acc   <= i_alu_out;
          r_cy    <= i_alu_c;
          r_state <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          // Carry out of the ALU is the bit falling off acc, which then
          // becomes the top bit of q in the following SHIFT_LO.
          r_acc   <= i_alu_out;
          r_cy    <= i_alu_c;
          r_state <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          r_q   <= i_alu_out;
          r_cy  <= 1'b0;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            // i_alu_out[0] is the next multiplier bit (the new q[0]).
            r_state <= i_alu_out[0] ? S_ADD : S_SHIFT_HI;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Moore decode of the ALU drive from the current state and registers.
  always_comb begin
    o_alu_sel = OP_NOP;
    o_alu_a   = 8'h00;
    o_alu_b   = 8'h00;
    o_alu_cin = 1'b0;
    unique case (r_state)
      S_ADD: begin
        o_alu_sel = OP_ADD;
        o_alu_a   = r_acc;
        o_alu_b   = r_m;
      end
      S_SHIFT_HI: begin
        o_alu_sel = OP_RRC;
        o_alu_b   = r_acc;
        o_alu_cin = r_cy;
      end
      S_SHIFT_LO: begin
        o_alu_sel = OP_RRC;
        o_alu_b   = r_q;
        o_alu_cin = r_cy;
      end
      default: begin
        o_alu_sel = OP_NOP;
      end
    endcase
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = {r_acc, r_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [7:0]  alu_out;
  logic        alu_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] prod;
    int          done_cyc;
    int          adds;
  } exp_t;

  exp_t sb[$];

  alu_mul_seq dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_a_in    (a_in),
    .i_b_in    (b_in),
    .o_busy    (busy),
    .o_done    (done),
    .o_product (product),
    .o_alu_a   (alu_a),
    .o_alu_b   (alu_b),
    .o_alu_sel (alu_sel),
    .o_alu_cin (alu_cin),
    .i_alu_out (alu_out),
    .i_alu_c   (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit ALU: ADD with carry, rotate-right-through-carry on B.
  always_comb begin
    alu_out = 8'h00;
    alu_c   = 1'b0;
    case (alu_sel)
      4'b0010: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      4'b0111: begin
        alu_out = {alu_cin, alu_b[7:1]};
        alu_c   = alu_b[0];
      end
      default: begin
        alu_out = 8'h00;
        alu_c   = 1'b0;
      end
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  int          add_cnt   = 0;
  logic [15:0] last_prod = 16'h0000;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      add_cnt   = 0;
      last_prod = 16'h0000;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_fall", {62'd0, busy, done}, 64'd0);
      prev_done = done;
      if (busy && alu_sel == 4'b0010) add_cnt++;
      if (!busy)
        chk("idle_outputs", {alu_sel, alu_a, alu_b, alu_cin, done, product},
            {4'h0, 8'h00, 8'h00, 1'b0, 1'b0, last_prod});
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("product", product, e.prod);
          chk("latency", cyc, e.done_cyc);
          chk("add_cycles", add_cnt, e.adds);
          chk("busy_with_done", busy, 1);
          last_prod = e.prod;
        end
        add_cnt = 0;
      end
    end
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int accept_cyc);
    exp_t e;
    e.prod     = 16'({8'h00, a} * {8'h00, b});
    e.adds     = $countones(b);
    e.done_cyc = accept_cyc + 16 + $countones(b);
    return e;
  endfunction

  task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) ok = 1'b1;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    n_fail++;
    summary();
    $fatal(1);
  end

  initial begin
    int e1;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, product, alu_sel, alu_a, alu_b, alu_cin}, 64'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Directed cases
    do_mul(8'd13, 8'd11);   wait_idle();
    chk("prod_13x11", product, 16'h008F);
    do_mul(8'hFF, 8'hFF);   wait_idle();
    chk("prod_ffxff", product, 16'hFE01);
    do_mul(8'hFF, 8'h00);   wait_idle();
    do_mul(8'h00, 8'hFF);   wait_idle();

    // start held high: two back-to-back acceptances, operands re-captured
    @(negedge clk);
    a_in  = 8'd3;
    b_in  = 8'd5;
    start = 1'b1;
    e1    = cyc + 1;
    sb.push_back(model(8'd3, 8'd5, e1));
    @(negedge clk);
    a_in = 8'd7;
    b_in = 8'd9;
    sb.push_back(model(8'd7, 8'd9, e1 + 16 + 2 + 2));
    wait_idle();
    start = 1'b0;
    chk("prod_7x9", product, 16'd63);

    // Asynchronous reset mid-operation
    do_mul(8'hAB, 8'hFF);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midop", {busy, done, product, alu_sel, alu_a, alu_b, alu_cin}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_mul(8'd2, 8'd2);     wait_idle();
    chk("prod_2x2", product, 16'd4);

    // Randomized operands with random idle gaps
    for (int i = 0; i < 20; i++) begin
      do_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 8x8 unsigned multiply controller that sequences the shared 8-bit ALU through shift-add steps. It issues ADD and RRC operations on the ALU select/operand/carry inputs, collects results and carry each cycle, and returns a 16-bit product with a one-cycle done pulse. It sits beside the ALU in the execute stage and drives the ALU only while busy; the ALU select mux gives it the ALU while `busy` is high.

## Interface
- No parameters. Widths are fixed to the 8-bit ALU.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a multiply; sampled only in IDLE.
- `a_in` in 8: multiplicand, captured when start is accepted.
- `b_in` in 8: multiplier, captured when start is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; product valid.
- `product` out 16: {acc, q}; held from done until the next accepted start.
- `alu_a` out 8: ALU operand A.
- `alu_b` out 8: ALU operand B.
- `alu_sel` out 4: ALU op. NOP=4'b0000, ADD=4'b0010, RRC=4'b0111.
- `alu_cin` out 1: ALU carry-in.
- `alu_out` in 8: ALU result, combinational in the same cycle.
- `alu_c` in 1: ALU carry flag, combinational in the same cycle.

## Operation
- Internal registers:
  - `m` (8): multiplicand.
  - `acc` (8): high half.
  - `q` (8): multiplier / low half.
  - `cy` (1): carry.
  - `cnt` (3): bit counter.
  - `state`.
- States: IDLE, ADD, SHIFT_HI, SHIFT_LO, DONE.
- Operations per state:
  - IDLE, DONE: alu_sel=NOP, alu_a=alu_b=0, alu_cin=0.
  - ADD: alu_sel=ADD, alu_a=acc, alu_b=m. acc<=alu_out, cy<=alu_c.
  - SHIFT_HI: alu_sel=RRC, alu_b=acc, alu_cin=cy, alu_a=0. acc<=alu_out, cy<=alu_c (old acc[0]).
  - SHIFT_LO: alu_sel=RRC, alu_b=q, alu_cin=cy, alu_a=0. q<=alu_out, cy<=0, cnt<=cnt+1.
- Transitions:
  - IDLE & start: m<=a_in, q<=b_in, acc<=0, cy<=0, cnt<=0. Go to ADD if b_in[0], else SHIFT_HI.
  - ADD goes to SHIFT_HI.
  - SHIFT_HI goes to SHIFT_LO.
  - SHIFT_LO with cnt==7 goes to DONE.
  - SHIFT_LO with cnt!=7 goes to ADD if alu_out[0] (next q[0]), else SHIFT_HI.
  - DONE goes to IDLE unconditionally.
- Skipped ADD: cy stays 0, so SHIFT_HI shifts in 0.
- Arithmetic: the 9-bit {cy, acc} sum never overflows 16 bits. Final {acc,q} = a_in*b_in, unsigned.
- Outputs are Moore: ALU drive signals, busy and done decode from state and registers only.

## Timing
- Reset (async, any state): state=IDLE; m, acc, q, cnt, cy = 0.
  - Outputs: busy=0, done=0, product=16'h0000, alu_sel=NOP, alu_a=alu_b=0, alu_cin=0.
  - Reset mid-multiply discards the operation; no done pulse.
- Start acceptance:
  - start is accepted on the rising edge where state==IDLE & start.
  - busy rises in the following cycle.
  - start is ignored in all other states, including DONE. Back-to-back multiplies therefore have one IDLE cycle between them.
- Latency:
  - N = 16 + popcount(b_in) cycles from the accepting edge to the edge that enters DONE.
  - done is high for exactly the one cycle after that edge. N=16 for b=0; N=24 for b=0xFF.
- busy: high from the cycle after acceptance through the DONE cycle inclusive. It falls together with done.
- product: changes only via acc/q updates while busy. Stable and correct throughout the DONE cycle and afterwards until the next acceptance.
- start held high continuously: a new operation is accepted on each IDLE cycle; operands are re-captured.

## Test plan
- Reset then idle, start=0: all outputs at their reset values. alu_sel stays 4'b0000 for 50 cycles.
- a=13, b=11 (popcount 3): done pulses exactly 19 cycles after the accepting edge. product=16'h008F; busy falls with done.
- a=0xFF, b=0xFF: latency 24, product=16'hFE01. The ADD cycles show alu_c=1 where expected, and cy is shifted into acc.
- a=0xFF, b=0x00, then a=0x00, b=0xFF: latency 16, product 0; latency 24, product 0. No ADD cycles in the first run.
- start held high, operands 3x5 then 7x9: products 15 and 63, each with one done pulse. Second acceptance is exactly 2 cycles after the first done edge; start asserted during the operation is ignored.
- rst_n dropped asynchronously mid-operation (cnt=4): outputs go to reset values immediately, with no done pulse. After release, 2x2 yields 4 with latency 17.
